stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 10, meaning 1 kHz edges per cs_tick (range 2..15).
REQ-002 SHALL have parameter LONG_MS, default 1000, meaning btn_lr hold time in ms for long-press clear (range 1..2047).
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clk  input  1  system clock, 125 MHz.
REQ-005 SHALL have port pls_1k  input  1  1 kHz timebase, clk-synchronous level; each rising edge is one ms.
REQ-006 SHALL have port btn_ss  input  1  debounced start/stop button level, active-high.
REQ-007 SHALL have port btn_lr  input  1  debounced lap/reset button level, active-high.
REQ-008 SHALL have port run  output  1  count enable, high in RUN and LAP.
REQ-009 SHALL have port lap_hold  output  1  display freeze, high in LAP only.
REQ-010 SHALL have port clr  output  1  one-clk pulse that clears the time counters.
REQ-011 SHALL have port cs_tick  output  1  one-clk centisecond advance pulse.
REQ-012 SHALL have port state  output  2  current state: IDLE=00, RUN=01, LAP=10, STOP=11.

Function
REQ-013 SHALL detect the pls_1k rising edge with two registers (p0<=pls_1k, p1<=p0); ms_edge = p0 & ~p1, one clk wide.
REQ-014 SHALL detect the btn_ss and btn_lr rising edges with one delay register each; ss_rise/lr_rise are one clk wide, with one clk latency after the input rises.
REQ-015 SHALL make the FSM transition on ss_rise: IDLE->RUN, RUN->STOP, LAP->STOP, STOP->RUN.
REQ-016 SHALL make the FSM transition on lr_rise (no ss_rise that cycle): RUN->LAP, LAP->RUN, STOP->IDLE with clr pulse; IDLE: no change.
REQ-017 SHALL give ss_rise priority over lr_rise when both occur in the same clk; lr_rise is then discarded.
REQ-018 SHALL keep an 11-bit hold counter that increments on ms_edge while btn_lr=1, saturates at LONG_MS, and clears to 0 in the clk where btn_lr=0.
REQ-019 SHALL fire long_press for exactly one clk when the hold counter reaches LONG_MS, once per press; long_press forces state IDLE and a clr pulse from any state, overriding ss_rise/lr_rise that cycle.
REQ-020 SHALL assert clr for exactly one clk, in the same clk that state becomes IDLE; clr is never asserted for two consecutive clks.
REQ-021 SHALL keep a 4-bit tick counter that advances on ms_edge only while run=1; at ms_edge with count=TICK_DIV-1 it wraps to 0 and cs_tick pulses for one clk.
REQ-022 SHALL hold the tick counter (no advance) in STOP and IDLE, and set it to 0 on clr.
REQ-023 SHALL not generate cs_tick in the clk the FSM leaves RUN/LAP; the registered run value gates ticking.
REQ-024 SHALL decode run, lap_hold and state from registered state with no combinational path from inputs; cs_tick and clr SHALL also be registered.
REQ-025 SHALL make LAP->STOP deassert lap_hold in the same clk that run deasserts.

Reset
REQ-026 SHALL, while rst=0, force state=IDLE, run=0, lap_hold=0, clr=0, cs_tick=0, tick counter=0, hold counter=0, and all edge registers=0.
REQ-027 SHALL, after rst releases, treat a button already high as not-risen until it falls and rises again.
REQ-028 SHALL, on reset mid-RUN, drop run immediately (asynchronously) and produce no clr pulse.

Verification
REQ-029 SHALL pass: rst release, btn_ss pulse -> state=01 and run=1; after 25 ms edges, exactly 2 cs_tick and tick counter=5.
REQ-030 SHALL pass: in RUN, btn_lr pulse -> state=10, lap_hold=1, cs_tick continues; second btn_lr pulse -> state=01, lap_hold=0.
REQ-031 SHALL pass: in RUN, btn_ss pulse -> state=11, no cs_tick for 50 ms; btn_lr pulse -> one clr pulse, state=00.
REQ-032 SHALL pass: btn_ss and btn_lr rising in the same clk from RUN -> state=11, lap_hold=0, no clr.
REQ-033 SHALL pass: in RUN, hold btn_lr for 1000 ms edges -> LAP after press, then exactly one clr and state=00 at the 1000th edge; holding to 1500 ms gives no further clr.
REQ-034 SHALL pass: assert rst in LAP with btn_lr held -> all outputs 0 at once; after release, no state change until btn_lr is re-pressed.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing FSM: start/stop, lap freeze, clear and long-press clear,
// plus the centisecond tick divider driven by the 1 kHz timebase.
//   state | meaning
//   IDLE  | cleared, not counting
//   RUN   | counting, display live
//   LAP   | counting, display frozen
//   STOP  | paused, time retained
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10,
  parameter int LONG_MS  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pls_1k,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic       run,
  output logic       lap_hold,
  output logic       clr,
  output logic       cs_tick,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } state_t;

  localparam logic [10:0] LONG_CNT = 11'(LONG_MS);
  localparam logic [10:0] LONG_M1  = 11'(LONG_MS - 1);
  localparam logic [3:0]  TDIV_M1  = 4'(TICK_DIV - 1);

  state_t      st_q, st_nx;
  logic        p0, p1, ss_d, lr_d;
  logic        armed, lr_arm;
  logic [10:0] hold_cnt;
  logic [3:0]  tick_cnt;
  logic        ms_edge, ss_rise, lr_rise;
  logic        hold_inc, long_press;
  logic        clr_nx, run_nx, tick_adv;

  // armed stays low for the first clk after reset so a button already held
  // at release only loads its delay register and never reads as a rise
  assign ms_edge    = p0 & ~p1;
  assign ss_rise    = btn_ss & ~ss_d & armed;
  assign lr_rise    = btn_lr & ~lr_d & armed;
  assign hold_inc   = ms_edge & btn_lr & (lr_arm | lr_rise) & (hold_cnt != LONG_CNT);
  assign long_press = hold_inc & (hold_cnt == LONG_M1);

  always_comb begin
    st_nx  = st_q;
    clr_nx = 1'b0;
    if (long_press) begin
      st_nx  = IDLE;
      clr_nx = ~clr;
    end else if (ss_rise) begin
      case (st_q)
        IDLE:    st_nx = RUN;
        RUN:     st_nx = STOP;
        LAP:     st_nx = STOP;
        default: st_nx = RUN;
      endcase
    end else if (lr_rise) begin
      case (st_q)
        RUN:  st_nx = LAP;
        LAP:  st_nx = RUN;
        STOP: begin
          st_nx  = IDLE;
          clr_nx = 1'b1;
        end
        default: st_nx = st_q;
      endcase
    end
  end

  // no advance in the clk the FSM leaves RUN/LAP
  assign run_nx   = (st_nx == RUN) || (st_nx == LAP);
  assign tick_adv = ms_edge & run & run_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= IDLE;
      p0       <= 1'b0;
      p1       <= 1'b0;
      ss_d     <= 1'b0;
      lr_d     <= 1'b0;
      armed    <= 1'b0;
      lr_arm   <= 1'b0;
      hold_cnt <= '0;
      tick_cnt <= '0;
      cs_tick  <= 1'b0;
      clr      <= 1'b0;
    end else begin
      st_q    <= st_nx;
      p0      <= pls_1k;
      p1      <= p0;
      ss_d    <= btn_ss;
      lr_d    <= btn_lr;
      armed   <= 1'b1;
      clr     <= clr_nx;
      cs_tick <= 1'b0;
      if (!btn_lr)      lr_arm <= 1'b0;
      else if (lr_rise) lr_arm <= 1'b1;
      if (!btn_lr)       hold_cnt <= '0;
      else if (hold_inc) hold_cnt <= hold_cnt + 11'd1;
      if (clr_nx) begin
        tick_cnt <= '0;
      end else if (tick_adv) begin
        if (tick_cnt == TDIV_M1) begin
          tick_cnt <= '0;
          cs_tick  <= 1'b1;
        end else begin
          tick_cnt <= tick_cnt + 4'd1;
        end
      end
    end
  end

  assign run      = (st_q == RUN) || (st_q == LAP);
  assign lap_hold = (st_q == LAP);
  assign state    = st_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: expected state changes, clr and
// cs_tick events are queued ahead of stimulus and matched by a monitor.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pls_1k = 1'b0, btn_ss = 1'b0, btn_lr = 1'b0;
  logic       run, lap_hold, clr, cs_tick;
  logic [1:0] state;

  stopwatch_ctrl dut (
    .clk(clk), .rst(rst), .pls_1k(pls_1k), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .run(run), .lap_hold(lap_hold), .clr(clr), .cs_tick(cs_tick), .state(state)
  );

  always #4 clk = ~clk;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] data;
  } ev_t;

  localparam logic [1:0] EV_ST = 2'd0, EV_CLR = 2'd1, EV_TICK = 2'd2;
  // state event data = {lap_hold, run, state}
  localparam logic [3:0] D_IDLE = 4'b0000, D_RUN = 4'b0101,
                         D_LAP = 4'b1110, D_STOP = 4'b0011;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_err = 0;
  logic       mon_en = 1'b0;
  logic [1:0] prev_state = 2'b00;

  function automatic void push(input logic [1:0] k, input logic [3:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  task automatic check_ev(input logic [1:0] k, input logic [3:0] d);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event kind=%0d data=%b required=none at %0t", k, d, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.data !== d) begin
        n_err++;
        $display("FAIL event kind=%0d data=%b required kind=%0d data=%b at %0t",
                 k, d, e.kind, e.data, $time);
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (clr) check_ev(EV_CLR, {2'b00, state});
      if (state != prev_state) begin
        check_ev(EV_ST, {lap_hold, run, state});
        prev_state = state;
      end
      if (cs_tick) check_ev(EV_TICK, 4'd0);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ms_edges(input int n);
    repeat (n) begin
      pls_1k = 1'b1;
      step(3);
      pls_1k = 1'b0;
      step(3);
    end
  endtask

  task automatic press_ss();
    btn_ss = 1'b1;
    step(3);
    btn_ss = 1'b0;
    step(3);
  endtask

  task automatic press_lr();
    btn_lr = 1'b1;
    step(3);
    btn_lr = 1'b0;
    step(3);
  endtask

  initial begin
    step(3);
    chk("rst_state", 16'(state), 16'd0);
    chk("rst_run", 16'(run), 16'd0);
    chk("rst_lap_hold", 16'(lap_hold), 16'd0);
    chk("rst_clr", 16'(clr), 16'd0);
    chk("rst_cs_tick", 16'(cs_tick), 16'd0);
    rst = 1'b1;
    step(2);
    mon_en = 1'b1;

    // start, 25 ms -> two ticks, divider left at 5
    push(EV_ST, D_RUN);
    press_ss();
    push(EV_TICK, 4'd0);
    push(EV_TICK, 4'd0);
    ms_edges(25);
    chk("tick_cnt_25ms", 16'(dut.tick_cnt), 16'd5);

    // lap freezes display but keeps ticking; second lap press resumes
    push(EV_ST, D_LAP);
    press_lr();
    push(EV_TICK, 4'd0);
    ms_edges(10);
    push(EV_ST, D_RUN);
    press_lr();

    // stop holds the divider; lap/reset from STOP clears
    push(EV_ST, D_STOP);
    press_ss();
    ms_edges(50);
    chk("tick_cnt_stop", 16'(dut.tick_cnt), 16'd5);
    push(EV_CLR, 4'd0);
    push(EV_ST, D_IDLE);
    press_lr();
    chk("tick_cnt_clr", 16'(dut.tick_cnt), 16'd0);

    // both buttons in the same clk: start/stop wins, no clr
    push(EV_ST, D_RUN);
    press_ss();
    push(EV_ST, D_STOP);
    btn_ss = 1'b1;
    btn_lr = 1'b1;
    step(3);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    step(3);
    push(EV_CLR, 4'd0);
    push(EV_ST, D_IDLE);
    press_lr();

    // long press from RUN: LAP, 99 ticks, clear at the 1000th edge, nothing more
    push(EV_ST, D_RUN);
    press_ss();
    push(EV_ST, D_LAP);
    for (int i = 0; i < 99; i++) push(EV_TICK, 4'd0);
    push(EV_CLR, 4'd0);
    push(EV_ST, D_IDLE);
    btn_lr = 1'b1;
    step(3);
    ms_edges(1500);
    chk("hold_cnt_sat", 16'(dut.hold_cnt), 16'd1000);
    btn_lr = 1'b0;
    step(3);

    // reset in LAP with lap/reset held; held buttons must not count as presses
    push(EV_ST, D_RUN);
    press_ss();
    push(EV_ST, D_LAP);
    btn_lr = 1'b1;
    step(3);
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_state", 16'(state), 16'd0);
    chk("async_run", 16'(run), 16'd0);
    chk("async_lap_hold", 16'(lap_hold), 16'd0);
    chk("async_clr", 16'(clr), 16'd0);
    btn_ss = 1'b1;
    step(3);
    prev_state = 2'b00;
    rst = 1'b1;
    mon_en = 1'b1;
    ms_edges(5);
    step(10);
    chk("held_btn_state", 16'(state), 16'd0);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    step(3);
    press_lr();
    push(EV_ST, D_RUN);
    press_ss();
    push(EV_ST, D_LAP);
    press_lr();

    step(10);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_events actual=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
